// File: rtl/atm_controller.sv
// atm_controller: card/PIN/transaction control FSM for an automatic cashier.
// Collects a 4-digit PIN, tracks failed attempts (warning, then lockout) and runs one
// deposit or withdrawal against a 64-bit balance. All outputs are registered.
module atm_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        tarjeta_recibida,
    input  logic        digito_stb,
    input  logic [3:0]  digito,
    input  logic [15:0] pin_correcto,
    output logic        pin_incorrecto,
    output logic        advertencia,
    output logic        bloqueo,
    input  logic        tipo_trans,
    input  logic [31:0] monto,
    input  logic [63:0] balance_inicial,
    output logic [63:0] balance_actualizado,
    output logic        balance_stb,
    output logic        entregar_dinero,
    output logic        fondos_insuficientes
);

    typedef enum logic [2:0] {
        StIdle,
        StPin,
        StCheck,
        StTrans,
        StBlock
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  intentos_q, intentos_d;
    logic [1:0]  digitos_q, digitos_d;
    logic [15:0] pin_sr_q, pin_sr_d;
    logic        pin_inc_q, pin_inc_d;
    logic        adv_q, adv_d;
    logic        bloq_q, bloq_d;
    logic [63:0] balance_q, balance_d;
    logic        bal_stb_q, bal_stb_d;
    logic        entregar_q, entregar_d;
    logic        fondos_q, fondos_d;
    logic [63:0] monto_ext;

    assign monto_ext = {32'd0, monto};

    // State and registered outputs; async reset returns everything to zero / IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            intentos_q <= 2'd0;
            digitos_q  <= 2'd0;
            pin_sr_q   <= 16'd0;
            pin_inc_q  <= 1'b0;
            adv_q      <= 1'b0;
            bloq_q     <= 1'b0;
            balance_q  <= 64'd0;
            bal_stb_q  <= 1'b0;
            entregar_q <= 1'b0;
            fondos_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            intentos_q <= intentos_d;
            digitos_q  <= digitos_d;
            pin_sr_q   <= pin_sr_d;
            pin_inc_q  <= pin_inc_d;
            adv_q      <= adv_d;
            bloq_q     <= bloq_d;
            balance_q  <= balance_d;
            bal_stb_q  <= bal_stb_d;
            entregar_q <= entregar_d;
            fondos_q   <= fondos_d;
        end
    end

    // Next-state and next-output logic; pulses default low, levels hold.
    always_comb begin
        state_d    = state_q;
        intentos_d = intentos_q;
        digitos_d  = digitos_q;
        pin_sr_d   = pin_sr_q;
        pin_inc_d  = 1'b0;
        adv_d      = adv_q;
        bloq_d     = bloq_q;
        balance_d  = balance_q;
        bal_stb_d  = 1'b0;
        entregar_d = 1'b0;
        fondos_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (tarjeta_recibida) begin
                    state_d   = StPin;
                    digitos_d = 2'd0;
                    pin_sr_d  = 16'd0;
                end
            end
            StPin: begin
                if (digito_stb) begin
                    pin_sr_d  = {pin_sr_q[11:0], digito};
                    digitos_d = digitos_q + 2'd1;
                    if (digitos_q == 2'd3) begin
                        state_d = StCheck;
                    end
                end
            end
            StCheck: begin
                if (pin_sr_q == pin_correcto) begin
                    state_d    = StTrans;
                    intentos_d = 2'd0;
                    adv_d      = 1'b0;
                end else begin
                    pin_inc_d  = 1'b1;
                    intentos_d = intentos_q + 2'd1;
                    digitos_d  = 2'd0;
                    pin_sr_d   = 16'd0;
                    // Third consecutive miss locks the card until reset.
                    if (intentos_q == 2'd2) begin
                        bloq_d  = 1'b1;
                        state_d = StBlock;
                    end else begin
                        state_d = StPin;
                        if (intentos_q == 2'd1) begin
                            adv_d = 1'b1;
                        end
                    end
                end
            end
            StTrans: begin
                state_d = StIdle;
                if (!tipo_trans) begin
                    balance_d = balance_inicial + monto_ext;
                    bal_stb_d = 1'b1;
                end else if (monto_ext <= balance_inicial) begin
                    balance_d  = balance_inicial - monto_ext;
                    bal_stb_d  = 1'b1;
                    entregar_d = 1'b1;
                end else begin
                    fondos_d = 1'b1;
                end
            end
            StBlock: begin
                bloq_d = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign pin_incorrecto       = pin_inc_q;
    assign advertencia          = adv_q;
    assign bloqueo              = bloq_q;
    assign balance_actualizado  = balance_q;
    assign balance_stb          = bal_stb_q;
    assign entregar_dinero      = entregar_q;
    assign fondos_insuficientes = fondos_q;

endmodule

// File: tb/tb_atm_controller.sv
// tb_atm_controller: table-driven cycle vectors for atm_controller plus a short
// hand-written sequence for pulse width and asynchronous reset.
module tb_atm_controller;

    logic        clk;
    logic        reset;
    logic        tarjeta_recibida;
    logic        digito_stb;
    logic [3:0]  digito;
    logic [15:0] pin_correcto;
    logic        pin_incorrecto;
    logic        advertencia;
    logic        bloqueo;
    logic        tipo_trans;
    logic [31:0] monto;
    logic [63:0] balance_inicial;
    logic [63:0] balance_actualizado;
    logic        balance_stb;
    logic        entregar_dinero;
    logic        fondos_insuficientes;

    int checks = 0;
    int errors = 0;

    atm_controller dut (
        .clk                 (clk),
        .reset               (reset),
        .tarjeta_recibida    (tarjeta_recibida),
        .digito_stb          (digito_stb),
        .digito              (digito),
        .pin_correcto        (pin_correcto),
        .pin_incorrecto      (pin_incorrecto),
        .advertencia         (advertencia),
        .bloqueo             (bloqueo),
        .tipo_trans          (tipo_trans),
        .monto               (monto),
        .balance_inicial     (balance_inicial),
        .balance_actualizado (balance_actualizado),
        .balance_stb         (balance_stb),
        .entregar_dinero     (entregar_dinero),
        .fondos_insuficientes(fondos_insuficientes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record per clock: inputs driven before the edge, outputs expected after it.
    // flags = {pin_incorrecto, advertencia, bloqueo, balance_stb, entregar_dinero, fondos}
    typedef struct {
        logic        rst;
        logic        card;
        logic        stb;
        logic [3:0]  dig;
        logic        tipo;
        logic [31:0] m;
        logic [63:0] b;
        logic [5:0]  flags;
        logic [63:0] bo;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic c, input logic s,
                                input logic [3:0] d, input logic t, input logic [31:0] m,
                                input logic [63:0] b, input logic [5:0] f,
                                input logic [63:0] bo);
        vec_t v;
        v.rst = r; v.card = c; v.stb = s; v.dig = d; v.tipo = t;
        v.m = m; v.b = b; v.flags = f; v.bo = bo;
        return v;
    endfunction

    function automatic logic [5:0] got_flags();
        return {pin_incorrecto, advertencia, bloqueo, balance_stb, entregar_dinero,
                fondos_insuficientes};
    endfunction

    task automatic check(input string name, input logic [5:0] ef, input logic [63:0] eb);
        checks++;
        if (got_flags() !== ef || balance_actualizado !== eb) begin
            errors++;
            $display("FAIL %s: got flags=%b bal=%0d, expected flags=%b bal=%0d",
                     name, got_flags(), balance_actualizado, ef, eb);
        end
    endtask

    task automatic drive(input logic c, input logic s, input logic [3:0] d, input logic t,
                         input logic [31:0] m, input logic [63:0] b);
        tarjeta_recibida = c; digito_stb = s; digito = d;
        tipo_trans = t; monto = m; balance_inicial = b;
    endtask

    initial begin
        pin_correcto = 16'h1234;
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);

        // T1: correct PIN, deposit 500 onto 1000 (strobe in IDLE is ignored)
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 6'b000000, 0));
        vecs.push_back(mk(1, 0, 1, 9, 0, 0, 0, 6'b000000, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 6'b000000, 0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 6'b000000, 0));
        vecs.push_back(mk(1, 0, 1, 2, 0, 0, 0, 6'b000000, 0));
        vecs.push_back(mk(1, 0, 1, 3, 0, 0, 0, 6'b000000, 0));
        vecs.push_back(mk(1, 0, 1, 4, 0, 0, 0, 6'b000000, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 6'b000000, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 500, 1000, 6'b000100, 1500));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 6'b000000, 1500));
        // T2: withdrawal 300 from 1000
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 6'b000000, 1500));
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 6'b000000, 1500));
        vecs.push_back(mk(1, 0, 1, 2, 0, 0, 0, 6'b000000, 1500));
        vecs.push_back(mk(1, 0, 1, 3, 0, 0, 0, 6'b000000, 1500));
        vecs.push_back(mk(1, 0, 1, 4, 0, 0, 0, 6'b000000, 1500));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 6'b000000, 1500));
        vecs.push_back(mk(1, 0, 0, 0, 1, 300, 1000, 6'b000110, 700));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 6'b000000, 700));
        // T3a: withdrawal 2000 from 1000 refused, balance held
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 6'b000000, 700));
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 6'b000000, 700));
        vecs.push_back(mk(1, 0, 1, 2, 0, 0, 0, 6'b000000, 700));
        vecs.push_back(mk(1, 0, 1, 3, 0, 0, 0, 6'b000000, 700));
        vecs.push_back(mk(1, 0, 1, 4, 0, 0, 0, 6'b000000, 700));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 6'b000000, 700));
        vecs.push_back(mk(1, 0, 0, 0, 1, 2000, 1000, 6'b000001, 700));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 6'b000000, 700));
        // T3b: withdrawal of the exact balance gives 0
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 6'b000000, 700));
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 6'b000000, 700));
        vecs.push_back(mk(1, 0, 1, 2, 0, 0, 0, 6'b000000, 700));
        vecs.push_back(mk(1, 0, 1, 3, 0, 0, 0, 6'b000000, 700));
        vecs.push_back(mk(1, 0, 1, 4, 0, 0, 0, 6'b000000, 700));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 6'b000000, 700));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1000, 1000, 6'b000110, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 6'b000000, 0));
        // T4: two misses (warning), then correct PIN clears the warning
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 6'b000000, 0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 6'b000000, 0));
        vecs.push_back(mk(1, 0, 1, 2, 0, 0, 0, 6'b000000, 0));
        vecs.push_back(mk(1, 0, 1, 3, 0, 0, 0, 6'b000000, 0));
        vecs.push_back(mk(1, 0, 1, 5, 0, 0, 0, 6'b000000, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 6'b100000, 0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 6'b000000, 0));
        vecs.push_back(mk(1, 0, 1, 2, 0, 0, 0, 6'b000000, 0));
        vecs.push_back(mk(1, 0, 1, 3, 0, 0, 0, 6'b000000, 0));
        vecs.push_back(mk(1, 0, 1, 5, 0, 0, 0, 6'b000000, 0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 6'b110000, 0)); // strobe during CHECK ignored
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 6'b010000, 0));
        vecs.push_back(mk(1, 0, 1, 2, 0, 0, 0, 6'b010000, 0));
        vecs.push_back(mk(1, 0, 1, 3, 0, 0, 0, 6'b010000, 0));
        vecs.push_back(mk(1, 0, 1, 4, 0, 0, 0, 6'b010000, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 6'b000000, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 7, 10, 6'b000100, 17));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 6'b000000, 17));
        // T6: reset after two digits, then a full session with 64-bit wraparound
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 6'b000000, 17));
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 6'b000000, 17));
        vecs.push_back(mk(1, 0, 1, 2, 0, 0, 0, 6'b000000, 17));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 6'b000000, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 6'b000000, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 6'b000000, 0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 6'b000000, 0));
        vecs.push_back(mk(1, 0, 1, 2, 0, 0, 0, 6'b000000, 0));
        vecs.push_back(mk(1, 0, 1, 3, 0, 0, 0, 6'b000000, 0));
        vecs.push_back(mk(1, 0, 1, 4, 0, 0, 0, 6'b000000, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 6'b000000, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 5, 64'hFFFF_FFFF_FFFF_FFFE, 6'b000100, 3));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 6'b000000, 3));
        // T5: three misses lock the card; inputs ignored until reset
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 6'b000000, 3));
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 6'b000000, 3));
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 6'b000000, 3));
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 6'b000000, 3));
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 6'b000000, 3));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 6'b100000, 3));
        vecs.push_back(mk(1, 0, 1, 2, 0, 0, 0, 6'b000000, 3));
        vecs.push_back(mk(1, 0, 1, 2, 0, 0, 0, 6'b000000, 3));
        vecs.push_back(mk(1, 0, 1, 2, 0, 0, 0, 6'b000000, 3));
        vecs.push_back(mk(1, 0, 1, 2, 0, 0, 0, 6'b000000, 3));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 6'b110000, 3));
        vecs.push_back(mk(1, 0, 1, 3, 0, 0, 0, 6'b010000, 3));
        vecs.push_back(mk(1, 0, 1, 3, 0, 0, 0, 6'b010000, 3));
        vecs.push_back(mk(1, 0, 1, 3, 0, 0, 0, 6'b010000, 3));
        vecs.push_back(mk(1, 0, 1, 3, 0, 0, 0, 6'b010000, 3));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 6'b111000, 3));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 6'b011000, 3));
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 6'b011000, 3));
        vecs.push_back(mk(1, 0, 1, 2, 0, 0, 0, 6'b011000, 3));
        vecs.push_back(mk(1, 0, 1, 3, 0, 0, 0, 6'b011000, 3));
        vecs.push_back(mk(1, 0, 1, 4, 0, 0, 0, 6'b011000, 3));
        vecs.push_back(mk(1, 0, 0, 0, 0, 5, 5, 6'b011000, 3));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 5, 6'b011000, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 6'b000000, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 6'b000000, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst;
            drive(vecs[i].card, vecs[i].stb, vecs[i].dig, vecs[i].tipo, vecs[i].m, vecs[i].b);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].flags, vecs[i].bo);
        end

        // Hand sequence: deposit pulse lasts one cycle, then async reset mid-cycle.
        drive(1, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        for (int k = 1; k <= 4; k++) begin
            drive(0, 1, 4'(k), 0, 0, 0);
            @(posedge clk); #1;
        end
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 42, 100);
        @(posedge clk); #1;
        check("hand_deposit", 6'b000100, 142);
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        check("hand_pulse_end", 6'b000000, 142);
        #2;
        reset = 1'b0;
        #1;
        check("hand_async_reset", 6'b000000, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("hand_idle_after_reset", 6'b000000, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
